// File: rtl/sub_serial.sv
// ----------------------------------------------------------------------------
// sub_serial -- multi-cycle N-bit subtractor (diff = a - b - bin)
//
// The subtract is done W bits per clock on a narrow slice datapath using
// a_slice + ~b_slice + carry, where carry = ~borrow. An accepted operation
// takes S = N/W RUN cycles. The result and the flags are registered and
// change only when the last slice completes.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request, sampled only while busy = 0
//   a      in   [N-1:0] minuend, sampled on the accepting edge
//   b      in   [N-1:0] subtrahend, sampled on the accepting edge
//   bin    in   borrow-in, sampled on the accepting edge
//   busy   out  high while an operation is in progress
//   done   out  one-cycle pulse; the result is valid from this cycle
//   diff   out  [N-1:0] (a - b - bin) mod 2^N
//   bout   out  borrow-out (unsigned a < b + bin)
//   zero   out  diff == 0
//   neg    out  diff[N-1]
//   ovf    out  signed overflow of the subtraction
// ----------------------------------------------------------------------------
module sub_serial #(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         zero,
  output logic         neg,
  output logic         ovf
);

  localparam int S  = N / W;
  localparam int KW = (S > 1) ? $clog2(S) : 1;

  generate
    if ((W < 1) || (N % W != 0)) begin : g_bad_params
      $error("sub_serial: N must be a positive multiple of W");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic [N-1:0]   work_diff;
  logic           borrow;
  logic [KW-1:0]  k;

  logic [W:0]     slice_sum;
  logic [N-1:0]   next_diff;
  logic           last_slice;

  // Slice adder. The top bit of slice_sum is the carry-out; borrow is its
  // complement, so borrow crosses slice boundaries just like a full-width
  // subtract.
  // NOTE: every always_comb output is given a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    slice_sum  = '0;
    next_diff  = work_diff;
    last_slice = (k == KW'(S - 1));
    slice_sum  = {1'b0, a_q[int'(k)*W +: W]}
               + {1'b0, ~b_q[int'(k)*W +: W]}
               + {{W{1'b0}}, ~borrow};
    next_diff[int'(k)*W +: W] = slice_sum[W-1:0];
  end

  // NOTE: all state here is sequential and uses non-blocking assignments, so
  // every register sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      work_diff <= '0;
      borrow    <= 1'b0;
      k         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q       <= a;
            b_q       <= b;
            borrow    <= bin;
            work_diff <= '0;
            k         <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          work_diff <= next_diff;
          borrow    <= ~slice_sum[W];
          if (last_slice) begin
            // Publish the result and all flags together from the final slice.
            diff  <= next_diff;
            bout  <= ~slice_sum[W];
            zero  <= (next_diff == '0);
            neg   <= next_diff[N-1];
            ovf   <= (a_q[N-1] != b_q[N-1]) && (next_diff[N-1] != a_q[N-1]);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_serial.sv
// ----------------------------------------------------------------------------
// tb_sub_serial -- self-checking bench for sub_serial (N=8, W=4).
// Inputs are driven and outputs sampled on the falling clock edge. Expected
// results come from plain integer arithmetic on a - b - bin.
// ----------------------------------------------------------------------------
module tb_sub_serial;

  localparam int N   = 8;
  localparam int W   = 4;
  localparam int LAT = N / W;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         bout;
  logic         zero;
  logic         neg;
  logic         ovf;

  int n_vec;
  int n_err;

  sub_serial #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .zero  (zero),
    .neg   (neg),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {diff, bout, zero, neg, ovf} straight from integer arithmetic.
  function automatic logic [N+3:0] model(input logic [N-1:0] ma,
                                         input logic [N-1:0] mb,
                                         input logic mbin);
    int          full;
    logic [N-1:0] d;
    full = int'(ma) - int'(mb) - int'(mbin);
    d    = N'(full & ((1 << N) - 1));
    return {d, (full < 0), (d == 0), d[N-1],
            (ma[N-1] != mb[N-1]) && (d[N-1] != ma[N-1])};
  endfunction

  function automatic logic [N+3:0] observed();
    return {diff, bout, zero, neg, ovf};
  endfunction

  // Present an operation for one edge (E0), then scramble the operand inputs.
  task automatic launch(input logic [N-1:0] ta, input logic [N-1:0] tb_,
                        input logic tbin);
    @(negedge clk);
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = N'($urandom); b = N'($urandom); bin = 1'($urandom);
  endtask

  // Count falling edges from just after E0 until done is seen (bounded).
  task automatic wait_done(output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b1;
    while (!done) begin
      if (cycles >= 20) begin
        ok = 1'b0;
        break;
      end
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic run_and_check(input string name, input logic [N-1:0] ta,
                               input logic [N-1:0] tb_, input logic tbin);
    int           cyc;
    bit           ok;
    logic [N+3:0] exp;
    exp = model(ta, tb_, tbin);
    launch(ta, tb_, tbin);
    wait_done(cyc, ok);
    n_vec++;
    if (!ok || cyc != LAT) begin
      n_err++;
      $display("FAIL %s latency: got %0d (done seen=%0b) want %0d", name, cyc, ok, LAT);
    end
    n_vec++;
    if (observed() !== exp) begin
      n_err++;
      $display("FAIL %s result a=%h b=%h bin=%0b: got {diff,bout,z,n,v}=%h want %h",
               name, ta, tb_, tbin, observed(), exp);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL %s done width: got done=%0b one cycle later want 0", name, done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({busy, done, observed()} !== '0) begin
      n_err++;
      $display("FAIL reset outputs: got %h want 0", {busy, done, observed()});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_and_check("basic", 8'h35, 8'h12, 1'b0);
    run_and_check("negative", 8'h12, 8'h35, 1'b0);
    run_and_check("overflow", 8'h80, 8'h01, 1'b0);
    run_and_check("zero_nibble_borrow", 8'h40, 8'h3F, 1'b1);
    run_and_check("max_borrow", 8'h00, 8'hFF, 1'b1);
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit ok;
    @(negedge clk);
    a = 8'h35; b = 8'h12; bin = 1'b0; start = 1'b1;
    @(negedge clk);                       // after E0: busy
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b busy after accept: got %0b want 1", busy);
    end
    a = 8'hFF; b = 8'h00; bin = 1'b0;     // start held: must be ignored
    @(negedge clk);                       // after E1
    start = 1'b0;
    wait_done(cyc, ok);
    n_vec++;
    if (!ok || observed() !== model(8'h35, 8'h12, 1'b0)) begin
      n_err++;
      $display("FAIL b2b ignored start: got %h want %h", observed(), model(8'h35, 8'h12, 1'b0));
    end
    // Start in the done cycle must be accepted.
    a = 8'h10; b = 8'h20; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'hAA; b = 8'h55;
    n_vec++;
    if (busy !== 1'b1 || diff !== 8'h23) begin
      n_err++;
      $display("FAIL b2b accept in done cycle: got busy=%0b diff=%h want busy=1 diff=23", busy, diff);
    end
    wait_done(cyc, ok);
    n_vec++;
    if (!ok || cyc + 1 != LAT + 1) begin
      n_err++;
      $display("FAIL b2b done spacing: got %0d want %0d", cyc + 1, LAT + 1);
    end
    n_vec++;
    if (observed() !== model(8'h10, 8'h20, 1'b0)) begin
      n_err++;
      $display("FAIL b2b second result: got %h want %h", observed(), model(8'h10, 8'h20, 1'b0));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    bit seen_done;
    launch(8'h77, 8'h11, 1'b0);           // now after E0, busy
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, observed()} !== '0) begin
      n_err++;
      $display("FAIL mid-run reset outputs: got %h want 0", {busy, done, observed()});
    end
    seen_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    n_vec++;
    if (seen_done) begin
      n_err++;
      $display("FAIL aborted op done: got done pulse want none");
    end
    run_and_check("after_reset", 8'h09, 8'h04, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      run_and_check("random", N'($urandom), N'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sub_serial.md
Name: sub_serial

Overview:
Multi-cycle N-bit subtractor for the 8-bit CPU ALU. It computes A - B - borrow_in W bits per clock, using slice arithmetic A + ~B + carry, with borrow = ~carry. It reuses a narrow slice datapath instead of a full-width chain and gives the ALU a start/busy/done handshake plus result flags. It is the subtract counterpart to the ALU's look-ahead add path.

Parameters:
N, 8, operand/result width in bits.
W, 4, bits processed per cycle (slice width). N must be an integer multiple of W and W >= 1; a violation is an elaboration error. S = N/W slice steps.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request; sampled only while busy=0.
a  in  N  minuend; sampled on the accepting edge.
b  in  N  subtrahend; sampled on the accepting edge.
bin  in  1  borrow-in; sampled on the accepting edge.
busy  out  1  high while an operation is in progress.
done  out  1  one-cycle pulse; the result is valid from this cycle.
diff  out  N  result (a - b - bin) mod 2^N.
bout  out  1  borrow-out; 1 when unsigned a < b + bin.
zero  out  1  diff == 0.
neg  out  1  diff[N-1].
ovf  out  1  signed overflow: (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]).

Behaviour:
- Reset (rst_n=0, asynchronous): FSM to IDLE. busy, done, diff, bout, zero, neg, ovf all 0. Working registers are cleared. Reset has priority over everything, including an operation in progress; no done is produced for an aborted operation.
- States: IDLE, RUN.
- IDLE: start=1 at edge E0 latches a, b and bin into working registers, sets slice index k=0 and borrow=bin, and moves to RUN. busy=1 from E0.
- RUN, edge E(k+1), k = 0..S-1:
  - Compute slice bits [k*W +: W] as a_slice + ~b_slice + ~borrow (W+1 bits wide).
  - Write the W-bit sum into the working difference.
  - borrow = ~carry_out.
  - k increments.
- At edge E(S), when the last slice is written:
  - diff, bout, zero, neg and ovf update together from the final working values.
  - busy=0, done=1, FSM returns to IDLE.
- done deasserts at the next edge unless a new operation completes there. Since S >= 1, done is never high for two consecutive cycles.
- Latency: start sampled at E0, done high during the cycle after E(S). For N=8, W=4 this is 2 cycles.
- Outputs diff/bout/zero/neg/ovf hold the previous result for the whole of RUN and update only at E(S). They hold indefinitely afterwards until the next completion.
- start while busy=1: ignored. Operands are not resampled and the operation in flight is unaffected.
- start during the done cycle: busy=0, so it is accepted at that edge (back-to-back throughput of one result per S+1 cycles).
- Changes to a, b or bin after the accepting edge have no effect on the operation in flight.
- W == N: S=1, single-cycle RUN, latency 1.
- Borrow propagates across slice boundaries exactly as in a full-width subtract. The result is bit-identical to (a - b - bin) for all inputs.

Test Plan:
1. N=8, W=4: a=0x35, b=0x12, bin=0, start pulse -> done exactly 2 cycles later; diff=0x23, bout=0, zero=0, neg=0, ovf=0.
2. a=0x12, b=0x35, bin=0 -> diff=0xDD, bout=1, neg=1, ovf=0, zero=0.
3. a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, neg=0, ovf=1. Then a=0x40, b=0x3F, bin=1 -> diff=0x00, zero=1, bout=0, with the borrow crossing the nibble boundary.
4. Start a=0x35, b=0x12. While busy, pulse start with a=0xFF, b=0x00 -> ignored, result 0x23. Assert start with a=0x10, b=0x20 in the done cycle -> accepted; next done gives diff=0xF0, bout=1, and done pulses are separated by exactly 3 cycles.
5. Assert rst_n=0 mid-RUN -> all outputs 0 immediately, no done pulse. Release reset, run a=0x09, b=0x04 -> diff=0x05, normal latency.
6. Random sweep, 1000 operand/bin triples -> diff, bout, zero, neg and ovf match the golden (a - b - bin) model every time.
